// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: synchronizes the master's SPI pins into clk,
// shifts bytes in on SD_CLK rising edges and out on falling edges (mode 0),
// keeps a one-byte transmit holding register, and frames 6-byte SD commands.
module sd_spi_responder #(
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SD_CLK,
  input  logic        SD_MOSI,
  input  logic        SD_CS,
  output logic        SD_MISO,
  input  logic [7:0]  tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  output logic        cmd_end_err
);

  typedef enum logic {HUNT, CMD} frame_state_t;

  // Synchronizer chains; ok_sync_reg marks when the chains hold real pin samples.
  logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, cs_sync_reg, ok_sync_reg;
  logic sclk_s, mosi_s, cs_s, sync_ok;

  logic sclk_prev_reg, cs_prev_reg, armed_reg, cs_active_reg;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, live;

  logic [2:0]  bit_cnt_reg;
  logic [7:0]  rx_shift_reg, rx_data_reg;
  logic        rx_valid_reg;

  logic [7:0]  tx_shift_reg, hold_reg, load_byte;
  logic        hold_full_reg, load_pending_reg, shift_load;

  frame_state_t state_reg;
  logic [2:0]  byte_cnt_reg;
  logic [5:0]  cmd_index_reg;
  logic [31:0] cmd_arg_reg;
  logic [6:0]  cmd_crc_reg;
  logic        cmd_end_err_reg, cmd_valid_reg;

  assign sclk_s  = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s    = cs_sync_reg[SYNC_STAGES-1];
  assign sync_ok = ok_sync_reg[SYNC_STAGES-1];

  // A falling CS only counts once a genuine high level was seen after reset,
  // so a CS held low across reset release never starts a byte.
  assign sclk_rise  = sclk_s & ~sclk_prev_reg;
  assign sclk_fall  = ~sclk_s & sclk_prev_reg;
  assign cs_fall    = armed_reg & cs_prev_reg & ~cs_s;
  assign cs_rise    = cs_s & ~cs_prev_reg;
  assign live       = cs_active_reg & ~cs_s;
  assign shift_load = cs_fall | (live & sclk_fall & load_pending_reg);
  // Holding register wins; an empty holding register lets a same-cycle tx_load bypass.
  assign load_byte  = hold_full_reg ? hold_reg : (tx_load ? tx_data : FILL_BYTE);

  assign SD_MISO     = cs_active_reg ? tx_shift_reg[7] : 1'b1;
  assign tx_ready    = ~hold_full_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign cmd_valid   = cmd_valid_reg;
  assign cmd_index   = cmd_index_reg;
  assign cmd_arg     = cmd_arg_reg;
  assign cmd_crc     = cmd_crc_reg;
  assign cmd_end_err = cmd_end_err_reg;

  // Pin synchronizers (CS idles high, SD_CLK idles low).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '1;
      ok_sync_reg   <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SD_CLK};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], SD_MOSI};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], SD_CS};
      ok_sync_reg   <= {ok_sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge history and chip-select session tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
      armed_reg     <= 1'b0;
      cs_active_reg <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
      armed_reg     <= armed_reg | (sync_ok & cs_s);
      if (cs_s)
        cs_active_reg <= 1'b0;
      else if (cs_fall)
        cs_active_reg <= 1'b1;
    end
  end

  // Receive path: sample MOSI on SD_CLK rising, publish every 8th bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg  <= 3'd0;
      rx_shift_reg <= 8'h00;
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (!live) begin
        bit_cnt_reg <= 3'd0;
      end else if (sclk_rise) begin
        rx_shift_reg <= {rx_shift_reg[6:0], mosi_s};
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          rx_data_reg  <= {rx_shift_reg[6:0], mosi_s};
          rx_valid_reg <= 1'b1;
        end
      end
    end
  end

  // Transmit path: load at CS fall or byte boundary, shift on SD_CLK falling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift_reg     <= FILL_BYTE;
      hold_reg         <= 8'h00;
      hold_full_reg    <= 1'b0;
      load_pending_reg <= 1'b0;
    end else begin
      if (shift_load)
        tx_shift_reg <= load_byte;
      else if (live && sclk_fall)
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};

      if (!live)
        load_pending_reg <= 1'b0;
      else if (sclk_rise && bit_cnt_reg == 3'd7)
        load_pending_reg <= 1'b1;
      else if (shift_load)
        load_pending_reg <= 1'b0;

      if (shift_load && hold_full_reg) begin
        hold_full_reg <= 1'b0;
      end else if (tx_load && !hold_full_reg && !shift_load) begin
        hold_reg      <= tx_data;
        hold_full_reg <= 1'b1;
      end
    end
  end

  // Command framer: hunt for a start byte, then collect argument and CRC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= HUNT;
      byte_cnt_reg    <= 3'd0;
      cmd_index_reg   <= 6'd0;
      cmd_arg_reg     <= 32'd0;
      cmd_crc_reg     <= 7'd0;
      cmd_end_err_reg <= 1'b0;
      cmd_valid_reg   <= 1'b0;
    end else begin
      cmd_valid_reg <= 1'b0;
      if (rx_valid_reg) begin
        case (state_reg)
          HUNT: begin
            if (rx_data_reg[7:6] == 2'b01) begin
              cmd_index_reg <= rx_data_reg[5:0];
              byte_cnt_reg  <= 3'd1;
              state_reg     <= CMD;
            end
          end
          CMD: begin
            if (byte_cnt_reg == 3'd5) begin
              cmd_crc_reg     <= rx_data_reg[7:1];
              cmd_end_err_reg <= ~rx_data_reg[0];
              cmd_valid_reg   <= 1'b1;
              byte_cnt_reg    <= 3'd0;
              state_reg       <= HUNT;
            end else begin
              cmd_arg_reg  <= {cmd_arg_reg[23:0], rx_data_reg};
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end else if (cs_rise) begin
        state_reg    <= HUNT;
        byte_cnt_reg <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: a bit-banged SPI master plus a byte-level
// reference model (holding register as a depth-1 queue, command decode from
// the bytes sent) checks directed scenarios and randomized frames.
module tb_sd_spi_responder;
  localparam int HALF = 8;
  localparam logic [7:0] FILL = 8'hFF;

  logic clk = 1'b0, reset = 1'b0;
  logic SD_CLK = 1'b0, SD_MOSI = 1'b0, SD_CS = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_load = 1'b0;
  logic SD_MISO, tx_ready, rx_valid, cmd_valid, cmd_end_err;
  logic [7:0] rx_data;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0] cmd_crc;

  int n_checks = 0, n_errors = 0;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        err;
  } cmd_t;

  logic [7:0] rx_q[$];
  cmd_t       cmd_q[$];
  logic [7:0] hold_q[$];
  logic [7:0] send_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sd_spi_responder dut (
    .clk(clk), .reset(reset), .SD_CLK(SD_CLK), .SD_MOSI(SD_MOSI), .SD_CS(SD_CS),
    .SD_MISO(SD_MISO), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .cmd_valid(cmd_valid),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .cmd_end_err(cmd_end_err)
  );

  // Record every rx and cmd pulse between clock edges.
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (cmd_valid) cmd_q.push_back({cmd_index, cmd_arg, cmd_crc, cmd_end_err});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master shifts nbits of mo (MSB first); mi collects MISO sampled at each rising edge.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      SD_MOSI = mo[7-i];
      tick(HALF);
      mi[7-i] = SD_MISO;
      SD_CLK = 1'b1;
      tick(HALF);
      SD_CLK = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_pop();
    if (hold_q.size() > 0) return hold_q.pop_front();
    return FILL;
  endfunction

  // Load the holding register through the model; readiness must match model occupancy.
  task automatic model_load(input logic [7:0] v);
    logic want;
    want = (hold_q.size() == 0);
    n_checks++;
    if (tx_ready !== want) begin
      n_errors++;
      $display("FAIL tx_ready_before_load got %b want %b", tx_ready, want);
    end
    if (want) hold_q.push_back(v);
    @(negedge clk);
    tx_load = 1'b1;
    tx_data = v;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // One CS-low session sending send_q; model predicts each byte the master reads.
  task automatic run_frame(input bit rand_loads);
    logic [7:0] mi;
    got_q.delete();
    exp_q.delete();
    rx_q.delete();
    cmd_q.delete();
    SD_CS = 1'b0;
    exp_q.push_back(model_pop());
    foreach (send_q[j]) begin
      spi_bits(send_q[j], 8, mi);
      got_q.push_back(mi);
      tick(6);
      exp_q.push_back(model_pop());
      if (rand_loads && $urandom_range(0, 2) == 0) model_load(8'($urandom));
    end
    tick(HALF);
    SD_CS = 1'b1;
    tick(4 * HALF);
  endtask

  task automatic check_rx_matches_sent(input string tag);
    n_checks++;
    if (rx_q.size() != send_q.size()) begin
      n_errors++;
      $display("FAIL %s_rx_count got %0d want %0d", tag, rx_q.size(), send_q.size());
    end else begin
      foreach (send_q[j]) begin
        n_checks++;
        if (rx_q[j] !== send_q[j]) begin
          n_errors++;
          $display("FAIL %s_rx_byte%0d got %h want %h", tag, j, rx_q[j], send_q[j]);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (SD_MISO !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || cmd_valid !== 1'b0 ||
        rx_data !== 8'h00 || cmd_index !== 6'd0 || cmd_arg !== 32'd0 || cmd_crc !== 7'd0 ||
        cmd_end_err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s got miso=%b rdy=%b rxv=%b cmdv=%b rx=%h idx=%h arg=%h crc=%h err=%b want 1 1 0 0 00 00 0 00 0",
               tag, SD_MISO, tx_ready, rx_valid, cmd_valid, rx_data, cmd_index, cmd_arg, cmd_crc, cmd_end_err);
    end
  endtask

  task automatic check_one_cmd(input string tag, input cmd_t want);
    n_checks++;
    if (cmd_q.size() != 1) begin
      n_errors++;
      $display("FAIL %s_cmd_count got %0d want 1", tag, cmd_q.size());
    end else begin
      n_checks++;
      if (cmd_q[0] !== want) begin
        n_errors++;
        $display("FAIL %s_cmd got idx=%0d arg=%h crc=%h err=%b want idx=%0d arg=%h crc=%h err=%b",
                 tag, cmd_q[0].idx, cmd_q[0].arg, cmd_q[0].crc, cmd_q[0].err,
                 want.idx, want.arg, want.crc, want.err);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(4);
    check_reset_values("reset_hold");
    reset = 1'b1;
    tick(8);
    check_reset_values("reset_release");
    $display("test_reset done");
  endtask

  task automatic test_cmd0();
    send_q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    run_frame(0);
    check_rx_matches_sent("cmd0");
    check_one_cmd("cmd0", '{idx: 6'd0, arg: 32'd0, crc: 7'h4A, err: 1'b0});
    foreach (got_q[j]) begin
      n_checks++;
      if (got_q[j] !== 8'hFF) begin
        n_errors++;
        $display("FAIL cmd0_miso%0d got %h want ff", j, got_q[j]);
      end
    end
    $display("test_cmd0 done");
  endtask

  task automatic test_tx_preload();
    logic [7:0] mi0, mi1;
    int waited;
    model_load(8'h01);
    void'(hold_q.pop_front());
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL preload_busy got tx_ready=%b want 0", tx_ready);
    end
    SD_CS = 1'b0;
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 20) begin
      tick(1);
      waited++;
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL preload_ready_at_cs got tx_ready=%b want 1 within 20 cycles", tx_ready);
    end
    spi_bits(8'hFF, 8, mi0);
    spi_bits(8'hFF, 8, mi1);
    tick(HALF);
    SD_CS = 1'b1;
    tick(4 * HALF);
    n_checks++;
    if (mi0 !== 8'h01 || mi1 !== 8'hFF) begin
      n_errors++;
      $display("FAIL preload_miso got %h %h want 01 ff", mi0, mi1);
    end
    $display("test_tx_preload done");
  endtask

  task automatic test_end_err();
    send_q = '{8'h51, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    run_frame(0);
    check_rx_matches_sent("cmd17");
    check_one_cmd("cmd17", '{idx: 6'd17, arg: 32'h12345678, crc: 7'h00, err: 1'b1});
    send_q = '{8'hFF, 8'h3F};
    run_frame(0);
    n_checks++;
    if (cmd_index !== 6'd17 || cmd_arg !== 32'h12345678 || cmd_end_err !== 1'b1 || cmd_q.size() != 0) begin
      n_errors++;
      $display("FAIL cmd17_hold got idx=%0d arg=%h err=%b ncmd=%0d want 17 12345678 1 0",
               cmd_index, cmd_arg, cmd_end_err, cmd_q.size());
    end
    $display("test_end_err done");
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    rx_q.delete();
    cmd_q.delete();
    SD_CS = 1'b0;
    spi_bits(8'h48, 8, mi);
    spi_bits(8'hAA, 8, mi);
    spi_bits(8'hBB, 8, mi);
    spi_bits(8'hCC, 4, mi);
    tick(2);
    SD_CS = 1'b1;
    tick(4 * HALF);
    n_checks++;
    if (rx_q.size() != 3 || cmd_q.size() != 0) begin
      n_errors++;
      $display("FAIL abort_partial got rx=%0d cmd=%0d want 3 0", rx_q.size(), cmd_q.size());
    end
    void'(model_pop());
    send_q = '{8'h77, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_frame(0);
    check_rx_matches_sent("cmd55");
    check_one_cmd("cmd55", '{idx: 6'd55, arg: 32'h01020304, crc: 7'h05, err: 1'b0});
    $display("test_abort done");
  endtask

  task automatic test_hold_full();
    model_load(8'h3C);
    model_load(8'hA5);
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_full_ready got %b want 0", tx_ready);
    end
    send_q = '{8'hFF, 8'hFF};
    run_frame(0);
    n_checks++;
    if (got_q[0] !== 8'h3C || got_q[1] !== 8'hFF) begin
      n_errors++;
      $display("FAIL hold_full_miso got %h %h want 3c ff", got_q[0], got_q[1]);
    end
    $display("test_hold_full done");
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] mi;
    rx_q.delete();
    cmd_q.delete();
    SD_CS = 1'b0;
    tick(HALF);
    void'(model_pop());
    model_load(8'h5A);
    spi_bits(8'h40, 4, mi);
    reset = 1'b0;
    #1;
    check_reset_values("reset_midbyte");
    tick(3);
    reset = 1'b1;
    hold_q.delete();
    spi_bits(8'h0F, 4, mi);
    spi_bits(8'h40, 8, mi);
    n_checks++;
    if (rx_q.size() != 0 || cmd_q.size() != 0 || SD_MISO !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_no_rx got rx=%0d cmd=%0d miso=%b want 0 0 1", rx_q.size(), cmd_q.size(), SD_MISO);
    end
    SD_CS = 1'b1;
    tick(4 * HALF);
    send_q = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
    run_frame(0);
    check_rx_matches_sent("post_reset");
    check_one_cmd("post_reset", '{idx: 6'd8, arg: 32'h000001AA, crc: 7'h43, err: 1'b0});
    n_checks++;
    if (got_q[0] !== 8'hFF) begin
      n_errors++;
      $display("FAIL post_reset_miso0 got %h want ff", got_q[0]);
    end
    $display("test_reset_midbyte done");
  endtask

  task automatic test_random();
    logic [7:0] b, b0, b5;
    logic [31:0] arg;
    int njunk;
    for (int it = 0; it < 8; it++) begin
      send_q.delete();
      if ($urandom_range(0, 1) == 1) model_load(8'($urandom));
      njunk = $urandom_range(0, 2);
      for (int k = 0; k < njunk; k++) begin
        b = 8'($urandom);
        if (b[7:6] == 2'b01) b[7] = 1'b1;
        send_q.push_back(b);
      end
      b0 = {2'b01, 6'($urandom)};
      arg = $urandom;
      b5 = 8'($urandom);
      send_q.push_back(b0);
      for (int k = 3; k >= 0; k--) send_q.push_back(arg[8*k +: 8]);
      send_q.push_back(b5);
      run_frame(1);
      check_rx_matches_sent("rand");
      check_one_cmd("rand", '{idx: b0[5:0], arg: arg, crc: b5[7:1], err: ~b5[0]});
      foreach (got_q[j]) begin
        n_checks++;
        if (got_q[j] !== exp_q[j]) begin
          n_errors++;
          $display("FAIL rand_miso%0d got %h want %h", j, got_q[j], exp_q[j]);
        end
      end
      $display("test_random frame %0d idx=%0d arg=%h bytes=%0d", it, b0[5:0], arg, send_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_tx_preload();
    test_end_err();
    test_abort();
    test_hold_full();
    test_reset_midbyte();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
